// File: rtl/seg7_scan_driver_if.sv
// Display-value inputs and active-low scan outputs of the seven-segment driver.
interface seg7_scan_driver_if;
    logic [7:0] bin_l;
    logic [7:0] bin_r;
    logic       dp_on;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output bin_l, bin_r, dp_on, input an, seg, dp);
    modport slave  (input bin_l, bin_r, dp_on, output an, seg, dp);
endinterface

// File: rtl/seg7_scan_driver.sv
// Converts two 0..99 binary values to BCD with a sequential double-dabble and
// time-multiplexes the four digits onto active-low anode/segment pins.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t        state;
    logic [7:0]    sh_l, sh_r;
    logic [7:0]    bcd_l, bcd_r;
    logic [2:0]    bit_cnt;
    logic [7:0]    disp_l, disp_r;
    logic [CW-1:0] ref_cnt;
    logic [1:0]    idx;
    logic [3:0]    digit;
    logic [7:0]    adj_l, adj_r;

    function automatic logic [7:0] sat99(input logic [7:0] v);
        return (v > 8'd99) ? 8'd99 : v;
    endfunction

    function automatic logic [7:0] add3(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
        if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign adj_l = add3(bcd_l);
    assign adj_r = add3(bcd_r);

    always_comb begin
        digit = disp_r[3:0];
        case (idx)
            2'd0: digit = disp_r[3:0];
            2'd1: digit = disp_r[7:4];
            2'd2: digit = disp_l[3:0];
            2'd3: digit = disp_l[7:4];
            default: digit = disp_r[3:0];
        endcase
    end

    // Conversion engine: 1 sample + 8 shift + 1 load = 10-cycle period.
    // Saturation to 99 keeps every intermediate value within two BCD nibbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sh_l    <= '0;
            sh_r    <= '0;
            bcd_l   <= '0;
            bcd_r   <= '0;
            bit_cnt <= '0;
            disp_l  <= '0;
            disp_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sh_l    <= sat99(bus.bin_l);
                    sh_r    <= sat99(bus.bin_r);
                    bcd_l   <= '0;
                    bcd_r   <= '0;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    {bcd_l, sh_l} <= {adj_l[6:0], sh_l, 1'b0};
                    {bcd_r, sh_r} <= {adj_r[6:0], sh_r, 1'b0};
                    bit_cnt       <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= LOAD;
                end
                LOAD: begin
                    disp_l <= bcd_l;
                    disp_r <= bcd_r;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Anode, segments and dp all derive from the same idx value in one
    // register stage, so a digit and its anode always change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
            bus.an  <= 4'b1111;
            bus.seg <= 7'b1111111;
            bus.dp  <= 1'b1;
        end else begin
            if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            bus.an  <= ~(4'b0001 << idx);
            bus.seg <= enc(digit);
            bus.dp  <= ~(bus.dp_on && (idx == 2'd2));
        end
    end
endmodule
